// File: rtl/sel_decoder_pkg.sv
// Shared types and helpers for the wait-state select decoder.
// Holds the FSM state encoding and the active-low one-hot decode.
package sel_decoder_pkg;

    localparam int unsigned ADDR_W_DFLT = 3;
    localparam int unsigned NSEL        = 2 ** ADDR_W_DFLT;
    localparam int unsigned MAX_ADDR_W  = 8;
    localparam int unsigned MAX_NSEL    = 2 ** MAX_ADDR_W;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEL  = 2'd1,
        ACK  = 2'd2
    } state_t;

    // Sized for the widest supported select code; callers cast down to their strobe count.
    function automatic logic [MAX_NSEL-1:0] decode_n(input logic [MAX_ADDR_W-1:0] code);
        logic [MAX_NSEL-1:0] v;
        v       = '1;
        v[code] = 1'b0;
        return v;
    endfunction

endpackage

// File: rtl/sel_decoder_ws_table.sv
// Per-select wait-state register file: async reset, synchronous write,
// combinational read so a request sees the value held before its edge.
module sel_ws_table
    import sel_decoder_pkg::*;
#(
    parameter int unsigned ADDR_W     = 3,
    parameter int unsigned WAIT_W     = 4,
    parameter int unsigned DEFAULT_WS = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WAIT_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [WAIT_W-1:0] rdata
);

    localparam int unsigned ENTRIES = 2 ** ADDR_W;

    logic [WAIT_W-1:0] mem [ENTRIES];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < ENTRIES; i++) begin
                mem[i] <= WAIT_W'(DEFAULT_WS);
            end
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/sel_decoder_ws.sv
// Clocked select decoder with held active-low strobes and a per-select
// programmable number of wait states before a registered acknowledge.
module sel_decoder_ws
    import sel_decoder_pkg::*;
#(
    parameter int unsigned ADDR_W     = 3,
    parameter int unsigned WAIT_W     = 4,
    parameter int unsigned DEFAULT_WS = 0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [ADDR_W-1:0]      a,
    input  logic                   e1_,
    input  logic                   e2_,
    input  logic                   e3,
    input  logic                   e4,
    input  logic                   rd_,
    input  logic                   wr_,
    input  logic                   cfg_we,
    input  logic [ADDR_W-1:0]      cfg_addr,
    input  logic [WAIT_W-1:0]      cfg_data,
    output logic [2**ADDR_W-1:0]   y_,
    output logic                   ack_,
    output logic                   busy,
    output logic                   err
);

    localparam int unsigned NUM_SEL = 2 ** ADDR_W;

    state_t              state, state_nx;
    logic [ADDR_W-1:0]   sel, sel_nx;
    logic [WAIT_W-1:0]   cnt, cnt_nx;
    logic [WAIT_W-1:0]   ws_rd;
    logic [NUM_SEL-1:0]  y_nx;
    logic                ack_nx;
    logic                busy_nx;
    logic                err_nx;
    logic                en;
    logic                req;
    logic                illegal;

    assign en      = ~e1_ & ~e2_ & e3 & e4;
    assign req     = en & (rd_ ^ wr_);
    assign illegal = en & ~rd_ & ~wr_;

    sel_ws_table #(
        .ADDR_W     (ADDR_W),
        .WAIT_W     (WAIT_W),
        .DEFAULT_WS (DEFAULT_WS)
    ) u_table (
        .clk   (clk),
        .rst   (rst),
        .we    (cfg_we),
        .waddr (cfg_addr),
        .wdata (cfg_data),
        .raddr (a),
        .rdata (ws_rd)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            sel   <= '0;
            cnt   <= '0;
            y_    <= '1;
            ack_  <= 1'b1;
            busy  <= 1'b0;
            err   <= 1'b0;
        end else begin
            state <= state_nx;
            sel   <= sel_nx;
            cnt   <= cnt_nx;
            y_    <= y_nx;
            ack_  <= ack_nx;
            busy  <= busy_nx;
            err   <= err_nx;
        end
    end

    // Outputs are computed one edge early here and registered, so y_/ack_/busy
    // already reflect the state being entered.
    always_comb begin
        state_nx = state;
        sel_nx   = sel;
        cnt_nx   = cnt;
        y_nx     = '1;
        ack_nx   = 1'b1;
        err_nx   = illegal;
        unique case (state)
            IDLE: begin
                if (req) begin
                    sel_nx   = a;
                    cnt_nx   = ws_rd;
                    y_nx     = NUM_SEL'(decode_n(MAX_ADDR_W'(a)));
                    state_nx = SEL;
                end
            end
            SEL: begin
                if (!req) begin
                    state_nx = IDLE;
                end else begin
                    y_nx = NUM_SEL'(decode_n(MAX_ADDR_W'(sel)));
                    if (cnt == '0) begin
                        state_nx = ACK;
                        ack_nx   = 1'b0;
                    end else begin
                        cnt_nx = cnt - WAIT_W'(1);
                    end
                end
            end
            ACK: begin
                if (!req) begin
                    state_nx = IDLE;
                end else begin
                    y_nx   = NUM_SEL'(decode_n(MAX_ADDR_W'(sel)));
                    ack_nx = 1'b0;
                end
            end
            default: state_nx = IDLE;
        endcase
        busy_nx = (state_nx != IDLE);
    end

endmodule

// File: tb/tb_sel_decoder_ws.sv
// Scoreboard bench: stimulus queues expected output changes with their cycle,
// a negedge monitor pops and compares whenever the DUT outputs change.
module tb_sel_decoder_ws;

    typedef struct {
        int         cyc;
        logic [7:0] y;
        logic       ack;
        logic       busy;
        logic       err;
    } ev_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] a = '0;
    logic       e1_ = 1'b0, e2_ = 1'b0, e3 = 1'b1, e4 = 1'b1;
    logic       rd_ = 1'b1, wr_ = 1'b1;
    logic       cfg_we = 1'b0;
    logic [2:0] cfg_addr = '0;
    logic [3:0] cfg_data = '0;
    logic [7:0] y_;
    logic       ack_, busy, err;

    int  cyc = 0;
    int  checks = 0;
    int  passes = 0;
    ev_t exp_q[$];
    logic [10:0] prev = 11'h7fc;

    sel_decoder_ws #(
        .ADDR_W     (3),
        .WAIT_W     (4),
        .DEFAULT_WS (0)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .a        (a),
        .e1_      (e1_),
        .e2_      (e2_),
        .e3       (e3),
        .e4       (e4),
        .rd_      (rd_),
        .wr_      (wr_),
        .cfg_we   (cfg_we),
        .cfg_addr (cfg_addr),
        .cfg_data (cfg_data),
        .y_       (y_),
        .ack_     (ack_),
        .busy     (busy),
        .err      (err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req_v);
        checks++;
        if (act === req_v) passes++;
        else $display("FAIL %s: got %h expected %h", name, act, req_v);
    endtask

    // dcyc = number of edges from now until the edge after which the change appears
    task automatic push(input int dcyc, input logic [7:0] y, input logic ack, input logic bsy, input logic er);
        ev_t ev;
        ev.cyc = cyc + dcyc; ev.y = y; ev.ack = ack; ev.busy = bsy; ev.err = er;
        exp_q.push_back(ev);
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic cfg_write(input logic [2:0] adr, input logic [3:0] dat);
        cfg_we = 1'b1; cfg_addr = adr; cfg_data = dat;
        step(1);
        cfg_we = 1'b0;
    endtask

    always @(negedge clk) begin
        if (rst) begin
            prev <= {y_, ack_, busy, err};
        end else if ({y_, ack_, busy, err} !== prev) begin
            prev <= {y_, ack_, busy, err};
            checks++;
            if (exp_q.size() == 0) begin
                $display("FAIL unexpected_event: cyc=%0d y_=%h ack_=%b busy=%b err=%b, none expected",
                         cyc, y_, ack_, busy, err);
            end else begin
                ev_t ev;
                ev = exp_q.pop_front();
                if (ev.cyc == cyc && ev.y === y_ && ev.ack === ack_ && ev.busy === busy && ev.err === err)
                    passes++;
                else
                    $display("FAIL event: got cyc=%0d y_=%h ack_=%b busy=%b err=%b expected cyc=%0d y_=%h ack_=%b busy=%b err=%b",
                             cyc, y_, ack_, busy, err, ev.cyc, ev.y, ev.ack, ev.busy, ev.err);
            end
        end
    end

    initial begin
        step(3);
        rst = 1'b0;
        step(1);
        chk("reset_state", {21'd0, y_, ack_, busy, err}, {21'd0, 8'hFF, 1'b1, 1'b0, 1'b0});

        // read a=5, default ws=0
        a = 3'd5; rd_ = 1'b0;
        push(1, 8'hDF, 1'b1, 1'b1, 1'b0);
        push(2, 8'hDF, 1'b0, 1'b1, 1'b0);
        step(2);
        rd_ = 1'b1;
        push(1, 8'hFF, 1'b1, 1'b0, 1'b0);
        step(2);

        // write a=2 with ws=3
        cfg_write(3'd2, 4'd3);
        a = 3'd2; wr_ = 1'b0;
        push(1, 8'hFB, 1'b1, 1'b1, 1'b0);
        push(5, 8'hFB, 1'b0, 1'b1, 1'b0);
        step(5);
        wr_ = 1'b1;
        push(1, 8'hFF, 1'b1, 1'b0, 1'b0);
        step(2);

        // ws=10 on a=7, a wiggles then request aborted before ack
        cfg_write(3'd7, 4'd10);
        a = 3'd7; rd_ = 1'b0;
        push(1, 8'h7F, 1'b1, 1'b1, 1'b0);
        step(1);
        a = 3'd0;
        step(3);
        rd_ = 1'b1;
        push(1, 8'hFF, 1'b1, 1'b0, 1'b0);
        step(2);

        // illegal request in IDLE
        rd_ = 1'b0; wr_ = 1'b0;
        push(1, 8'hFF, 1'b1, 1'b0, 1'b1);
        push(2, 8'hFF, 1'b1, 1'b0, 1'b0);
        step(1);
        rd_ = 1'b1; wr_ = 1'b1;
        step(2);

        // both low mid-transaction: abort plus err pulse
        a = 3'd3; rd_ = 1'b0;
        push(1, 8'hF7, 1'b1, 1'b1, 1'b0);
        push(2, 8'hF7, 1'b0, 1'b1, 1'b0);
        step(2);
        wr_ = 1'b0;
        push(1, 8'hFF, 1'b1, 1'b0, 1'b1);
        push(2, 8'hFF, 1'b1, 1'b0, 1'b0);
        step(1);
        rd_ = 1'b1; wr_ = 1'b1;
        step(2);

        // ws=2 on a=1, rewrite to 9 on the request edge: old value used now
        cfg_write(3'd1, 4'd2);
        a = 3'd1; rd_ = 1'b0;
        cfg_we = 1'b1; cfg_addr = 3'd1; cfg_data = 4'd9;
        push(1, 8'hFD, 1'b1, 1'b1, 1'b0);
        push(4, 8'hFD, 1'b0, 1'b1, 1'b0);
        step(1);
        cfg_we = 1'b0;
        step(3);
        rd_ = 1'b1;
        push(1, 8'hFF, 1'b1, 1'b0, 1'b0);
        step(2);
        rd_ = 1'b0;
        push(1, 8'hFD, 1'b1, 1'b1, 1'b0);
        push(11, 8'hFD, 1'b0, 1'b1, 1'b0);
        step(11);
        rd_ = 1'b1;
        push(1, 8'hFF, 1'b1, 1'b0, 1'b0);
        step(2);

        // release via enable drop while in ACK
        a = 3'd6; wr_ = 1'b0;
        push(1, 8'hBF, 1'b1, 1'b1, 1'b0);
        push(2, 8'hBF, 1'b0, 1'b1, 1'b0);
        step(3);
        e3 = 1'b0; wr_ = 1'b1;
        push(1, 8'hFF, 1'b1, 1'b0, 1'b0);
        step(1);
        e3 = 1'b1;
        step(2);

        // async reset in the middle of a ws=5 wait
        cfg_write(3'd4, 4'd5);
        a = 3'd4; rd_ = 1'b0;
        push(1, 8'hEF, 1'b1, 1'b1, 1'b0);
        step(3);
        rst = 1'b1; rd_ = 1'b1;
        #1;
        chk("async_rst_y", {24'd0, y_}, 32'h0000_00FF);
        chk("async_rst_ack", {31'd0, ack_}, 32'd1);
        chk("async_rst_busy", {31'd0, busy}, 32'd0);
        step(1);
        rst = 1'b0;
        step(1);
        rd_ = 1'b0;
        push(1, 8'hEF, 1'b1, 1'b1, 1'b0);
        push(2, 8'hEF, 1'b0, 1'b1, 1'b0);
        step(2);
        rd_ = 1'b1;
        push(1, 8'hFF, 1'b1, 1'b0, 1'b0);
        step(3);

        chk("pending_events", exp_q.size(), 32'd0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
